// File: rtl/instruction_cache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package instruction_cache_pkg;

    localparam int ADDR_W         = 29;  // word address, byte-address bits [30:2]
    localparam int DATA_W         = 32;
    localparam int DEF_LINES      = 16;
    localparam int DEF_LINE_WORDS = 4;

    localparam logic [DATA_W-1:0] INSTR_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        LOOKUP,
        REFILL,
        UPDATE
    } state_t;

    function automatic int off_w(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int idx_w(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_w(input int lines, input int line_words);
        return ADDR_W - $clog2(lines) - $clog2(line_words);
    endfunction

endpackage

// File: rtl/instruction_cache_if.sv
// Word-read handshake between the instruction cache (master) and instruction memory (slave).
interface instruction_cache_if;
    import instruction_cache_pkg::*;

    logic              mem_read;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_valid;
    logic [DATA_W-1:0] mem_data;

    modport master (output mem_read, mem_address, input mem_valid, mem_data);
    modport slave  (input mem_read, mem_address, output mem_valid, mem_data);

endinterface

// File: rtl/icache_refill_fsm.sv
// Refill sequencer: walks a missing line from offset 0 upward, one handshake per word.
module icache_refill_fsm
    import instruction_cache_pkg::*;
#(
    parameter int LINES      = DEF_LINES,
    parameter int LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 miss_i,
    input  logic [ADDR_W-off_w(LINE_WORDS)-1:0]  line_addr_i,
    output state_t                               state_o,
    output logic [off_w(LINE_WORDS)-1:0]         count_o,
    output logic                                 data_we_o,
    output logic                                 line_we_o,
    instruction_cache_if.master                  mem
);

    localparam int OFF_W = off_w(LINE_WORDS);
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

    state_t             state_q, state_d;
    logic [OFF_W-1:0]   count_q, count_d;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d         = state_q;
        count_d         = count_q;
        data_we_o       = 1'b0;
        line_we_o       = 1'b0;
        mem.mem_read    = 1'b0;
        mem.mem_address = {line_addr_i, count_q};
        case (state_q)
            LOOKUP: begin
                if (miss_i) begin
                    state_d = REFILL;
                    count_d = '0;
                end
            end
            REFILL: begin
                mem.mem_read = 1'b1;
                if (mem.mem_valid) begin
                    data_we_o = 1'b1;
                    count_d   = count_q + OFF_W'(1);
                    if (count_q == LAST_WORD) begin
                        line_we_o = 1'b1;
                        state_d   = UPDATE;
                    end
                end
            end
            UPDATE:  state_d = LOOKUP;
            default: state_d = LOOKUP;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= LOOKUP;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign state_o = state_q;
    assign count_o = count_q;

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache; define ICACHE_PERF_COUNTERS_EN to add hit/miss counters.
module instruction_cache
    import instruction_cache_pkg::*;
#(
    parameter int LINES      = DEF_LINES,
    parameter int LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] cache_address_i,
    input  logic              flush_i,
    output logic [DATA_W-1:0] instruction_o,
    output logic              stall_o,
`ifdef ICACHE_PERF_COUNTERS_EN
    output logic [31:0]       hit_count_o,
    output logic [31:0]       miss_count_o,
`endif
    instruction_cache_if.master mem
);

    localparam int OFF_W = off_w(LINE_WORDS);
    localparam int IDX_W = idx_w(LINES);
    localparam int TAG_W = tag_w(LINES, LINE_WORDS);

    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic              req_valid_q, req_valid_d;
    logic [LINES-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [TAG_W-1:0]  tag_d  [LINES];
    logic [DATA_W-1:0] data_q [LINES][LINE_WORDS];
    logic [DATA_W-1:0] data_d [LINES][LINE_WORDS];

    logic [OFF_W-1:0] req_off, refill_cnt;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic             hit, miss, data_we, line_we;
    state_t           state;

    assign req_off = req_addr_q[OFF_W-1:0];
    assign req_idx = req_addr_q[OFF_W +: IDX_W];
    assign req_tag = req_addr_q[ADDR_W-1 -: TAG_W];

    assign hit           = req_valid_q & valid_q[req_idx] & (tag_q[req_idx] == req_tag);
    assign miss          = req_valid_q & ~hit;
    assign stall_o       = (state != LOOKUP) | miss;
    assign instruction_o = hit ? data_q[req_idx][req_off] : INSTR_NOP;

    icache_refill_fsm #(
        .LINES      (LINES),
        .LINE_WORDS (LINE_WORDS)
    ) u_refill_fsm (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .miss_i      (miss),
        .line_addr_i (req_addr_q[ADDR_W-1:OFF_W]),
        .state_o     (state),
        .count_o     (refill_cnt),
        .data_we_o   (data_we),
        .line_we_o   (line_we),
        .mem         (mem)
    );

    // Flush is only honoured while not stalling, which also implies LOOKUP.
    always_comb begin
        req_addr_d  = req_addr_q;
        req_valid_d = req_valid_q;
        valid_d     = valid_q;
        tag_d       = tag_q;
        data_d      = data_q;
        if (!stall_o) begin
            req_addr_d  = cache_address_i;
            req_valid_d = 1'b1;
            if (flush_i) valid_d = '0;
        end
        if (data_we) data_d[req_idx][refill_cnt] = mem.mem_data;
        if (line_we) begin
            tag_d[req_idx]   = req_tag;
            valid_d[req_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_addr_q  <= '0;
            req_valid_q <= 1'b0;
            valid_q     <= '0;
        end else begin
            req_addr_q  <= req_addr_d;
            req_valid_q <= req_valid_d;
            valid_q     <= valid_d;
        end
    end

    // NOTE: tag and data arrays are not reset; the valid bits alone make stale contents unobservable.
    always_ff @(posedge clk_i) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

`ifdef ICACHE_PERF_COUNTERS_EN
    logic [31:0] hit_count_q, hit_count_d, miss_count_q, miss_count_d;

    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (state == LOOKUP && hit)  hit_count_d  = hit_count_q + 32'd1;
        if (state == LOOKUP && miss) miss_count_d = miss_count_q + 32'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count_o  = hit_count_q;
    assign miss_count_o = miss_count_q;
`endif

endmodule

// File: tb/tb_instruction_cache.sv
// Directed self-checking bench for instruction_cache (LINES=16, LINE_WORDS=4) with a zero/multi-wait memory model.
module tb_instruction_cache;
    import instruction_cache_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic [28:0] cache_address;
    logic [31:0] instruction;
    logic        stall;
`ifdef ICACHE_PERF_COUNTERS_EN
    logic [31:0] hit_count, miss_count;
`endif

    int tests = 0;
    int fails = 0;

    instruction_cache_if mem_bus ();

    instruction_cache #(.LINES(16), .LINE_WORDS(4)) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .cache_address_i (cache_address),
        .flush_i         (flush_i),
        .instruction_o   (instruction),
        .stall_o         (stall),
`ifdef ICACHE_PERF_COUNTERS_EN
        .hit_count_o     (hit_count),
        .miss_count_o    (miss_count),
`endif
        .mem             (mem_bus)
    );

    always #5 clk = ~clk;

    // Memory model: word contents are a fixed scramble of the address; wait_states idle cycles per word.
    int wait_states = 0;
    int wait_cnt    = 0;

    function automatic logic [31:0] mem_word(input logic [28:0] a);
        return ({3'b000, a} * 32'd2654435761) ^ 32'h1357_9BDF;
    endfunction

    assign mem_bus.mem_valid = mem_bus.mem_read && (wait_cnt == wait_states);
    assign mem_bus.mem_data  = mem_word(mem_bus.mem_address);

    always @(posedge clk) begin
        if (mem_bus.mem_read && !mem_bus.mem_valid) wait_cnt <= wait_cnt + 1;
        else                                        wait_cnt <= 0;
    end

    logic [28:0] word_log[$];
    int          unstable;

    // Present addr (and optionally flush) at a falling edge, then sample every falling edge until stall drops.
    task automatic fetch(input logic [28:0] addr, input logic flush,
                         output int stalls, output logic [31:0] instr);
        logic [28:0] prev_addr = '0;
        logic        prev_wait = 1'b0;
        cache_address = addr;
        flush_i       = flush;
        stalls        = 0;
        unstable      = 0;
        word_log.delete();
        @(posedge clk);
        @(negedge clk);
        flush_i = 1'b0;
        while (stall) begin
            if (mem_bus.mem_read) begin
                if (prev_wait && mem_bus.mem_address != prev_addr) unstable++;
                if (mem_bus.mem_valid) word_log.push_back(mem_bus.mem_address);
                prev_wait = !mem_bus.mem_valid;
                prev_addr = mem_bus.mem_address;
            end else begin
                prev_wait = 1'b0;
            end
            stalls++;
            if (stalls > 100) begin
                stalls = -1;
                break;
            end
            @(posedge clk);
            @(negedge clk);
        end
        instr = instruction;
    endtask

    task automatic test_miss(input string name, input logic [28:0] addr,
                             input logic flush, input int exp_stalls);
        int          s;
        logic [31:0] ins;
        logic [28:0] base;
        base = {addr[28:2], 2'b00};
        fetch(addr, flush, s, ins);
        tests++;
        if (s !== exp_stalls) begin
            fails++;
            $display("FAIL %s stall_cycles: got %0d expected %0d", name, s, exp_stalls);
        end
        tests++;
        if (word_log.size() !== 4) begin
            fails++;
            $display("FAIL %s refill_words: got %0d expected 4", name, word_log.size());
        end
        for (int k = 0; k < 4 && k < word_log.size(); k++) begin
            tests++;
            if (word_log[k] !== base + 29'(k)) begin
                fails++;
                $display("FAIL %s mem_address[%0d]: got %h expected %h", name, k, word_log[k], base + 29'(k));
            end
        end
        tests++;
        if (unstable !== 0) begin
            fails++;
            $display("FAIL %s address_stable: got %0d changes expected 0", name, unstable);
        end
        tests++;
        if (ins !== mem_word(addr)) begin
            fails++;
            $display("FAIL %s instruction: got %h expected %h", name, ins, mem_word(addr));
        end
        tests++;
        if (mem_bus.mem_read !== 1'b0) begin
            fails++;
            $display("FAIL %s mem_read_after: got %b expected 0", name, mem_bus.mem_read);
        end
    endtask

    task automatic test_hit(input string name, input logic [28:0] addr);
        int          s;
        logic [31:0] ins;
        fetch(addr, 1'b0, s, ins);
        tests++;
        if (s !== 0) begin
            fails++;
            $display("FAIL %s stall_cycles: got %0d expected 0", name, s);
        end
        tests++;
        if (word_log.size() !== 0) begin
            fails++;
            $display("FAIL %s mem_reads: got %0d expected 0", name, word_log.size());
        end
        tests++;
        if (ins !== mem_word(addr)) begin
            fails++;
            $display("FAIL %s instruction: got %h expected %h", name, ins, mem_word(addr));
        end
    endtask

    task automatic test_reset;
        rst_i         = 1'b1;
        flush_i       = 1'b0;
        cache_address = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        tests++;
        if (stall !== 1'b0) begin
            fails++;
            $display("FAIL reset stall: got %b expected 0", stall);
        end
        tests++;
        if (instruction !== 32'h0000_0013) begin
            fails++;
            $display("FAIL reset instruction: got %h expected 00000013", instruction);
        end
        tests++;
        if (mem_bus.mem_read !== 1'b0) begin
            fails++;
            $display("FAIL reset mem_read: got %b expected 0", mem_bus.mem_read);
        end
`ifdef ICACHE_PERF_COUNTERS_EN
        tests++;
        if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
            fails++;
            $display("FAIL reset counters: got %0d/%0d expected 0/0", hit_count, miss_count);
        end
`endif
    endtask

    task automatic test_cold_miss;
        test_miss("cold_miss", 29'h10, 1'b0, 6);
`ifdef ICACHE_PERF_COUNTERS_EN
        tests++;
        if (miss_count !== 32'd1 || hit_count !== 32'd0) begin
            fails++;
            $display("FAIL cold_miss counters: got %0d/%0d expected 0/1", hit_count, miss_count);
        end
`endif
    endtask

    task automatic test_back_to_back;
        test_hit("seq_hit_11", 29'h11);
        test_hit("seq_hit_12", 29'h12);
        test_hit("seq_hit_13", 29'h13);
`ifdef ICACHE_PERF_COUNTERS_EN
        tests++;
        if (hit_count !== 32'd3 || miss_count !== 32'd1) begin
            fails++;
            $display("FAIL seq_hit counters: got %0d/%0d expected 3/1", hit_count, miss_count);
        end
`endif
    endtask

    task automatic test_conflict;
        test_miss("conflict_110", 29'h110, 1'b0, 6);
        test_miss("conflict_10",  29'h10,  1'b0, 6);
        test_hit ("conflict_hit_13", 29'h13);
    endtask

    task automatic test_wait_states;
        wait_states = 2;
        test_miss("wait_22", 29'h22, 1'b0, 14);
        wait_states = 0;
        test_hit("wait_hit_20", 29'h20);
    endtask

    task automatic test_flush;
        test_hit ("flush_pre_hit", 29'h10);
        test_miss("flush_12", 29'h12, 1'b1, 6);
        test_miss("flush_other_line", 29'h23, 1'b0, 6);
    endtask

    task automatic test_reset_mid_refill;
        int words = 0;
        cache_address = 29'h30;
        for (int c = 0; c < 50 && words < 2; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (mem_bus.mem_read && mem_bus.mem_valid) words++;
        end
        @(posedge clk);
        @(negedge clk);
        rst_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tests++;
        if (words !== 2) begin
            fails++;
            $display("FAIL mid_reset words_before: got %0d expected 2", words);
        end
        tests++;
        if (mem_bus.mem_read !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset mem_read: got %b expected 0", mem_bus.mem_read);
        end
        tests++;
        if (stall !== 1'b0 || instruction !== 32'h0000_0013) begin
            fails++;
            $display("FAIL mid_reset outputs: got stall=%b instr=%h expected 0/00000013", stall, instruction);
        end
        rst_i = 1'b0;
        test_miss("mid_reset_refill", 29'h31, 1'b0, 6);
    endtask

    task automatic test_boundary;
        test_miss("last_line", 29'h3F, 1'b0, 6);
        test_miss("next_tag_idx0", 29'h40, 1'b0, 6);
        test_hit ("last_line_hit", 29'h3C);
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_back_to_back();
        test_conflict();
        test_wait_states();
        test_flush();
        test_reset_mid_refill();
        test_boundary();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
